fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC/address width (>=32).
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr  out  ADDR_W  instruction memory fetch address (combinational read).
REQ-007 SHALL have port imem_rdata  in  32  instruction at imem_addr, same cycle.
REQ-008 SHALL have port redirect  in  1  branch-taken/flush request.
REQ-009 SHALL have port redirect_mode  in  2  00 cond (19-bit offset), 01 uncond (26-bit offset), 10 register, 11 resync to redirect_pc+4.
REQ-010 SHALL have port redirect_pc  in  ADDR_W  PC of the branching instruction.
REQ-011 SHALL have port redirect_imm  in  26  raw offset field; modes 00 use [18:0], 01 use [25:0].
REQ-012 SHALL have port redirect_reg  in  ADDR_W  target for mode 10.
REQ-013 SHALL have port out_valid  out  1  queue head valid.
REQ-014 SHALL have port out_ready  in  1  consumer accepts head.
REQ-015 SHALL have port out_instr  out  32  head instruction.
REQ-016 SHALL have port out_pc  out  ADDR_W  head PC.
REQ-017 SHALL have port out_pc_plus4  out  ADDR_W  head PC+4 (link value).
REQ-018 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.
REQ-019 SHALL have port misalign  out  1  one-cycle pulse: mode-10 target had nonzero bits [1:0].

Function
REQ-020 SHALL hold fetch_pc register; imem_addr = fetch_pc at all times.
REQ-021 Push: when redirect=0 and (count<DEPTH or pop this cycle), SHALL enqueue {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc+4.
REQ-022 Pop SHALL occur when out_valid & out_ready; head advances next edge.
REQ-023 Queue SHALL be circular, head/tail pointers wrap mod DEPTH; simultaneous push+pop leaves count unchanged, including at full.
REQ-024 When full and no pop, SHALL not push and SHALL hold fetch_pc.
REQ-025 out_valid SHALL equal (count!=0); out_* SHALL be registered queue-head contents, never combinational from imem_rdata.
REQ-026 Redirect target: mode 00 redirect_pc + (sext(imm[18:0])<<2); 01 redirect_pc + (sext(imm[25:0])<<2); 10 {redirect_reg[ADDR_W-1:2],2'b00}; 11 redirect_pc+4.
REQ-027 All address arithmetic SHALL be modulo 2^ADDR_W (wrap, no flag).
REQ-028 On redirect: count <= 0, pointers reset, fetch_pc <= target, no push that cycle; a pop in the same cycle is still honoured (consumer owns it).
REQ-029 Redirect has priority over push; redirect asserted continuously re-targets every cycle, queue stays empty.
REQ-030 Latency: redirect at edge t -> target fetched in cycle t+1 -> out_valid with out_pc=target at t+2.
REQ-031 misalign SHALL pulse for the cycle after a mode-10 redirect with redirect_reg[1:0]!=0; 0 otherwise.

Reset
REQ-032 reset_n low SHALL immediately (asynchronously) set fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, misalign=0.
REQ-033 Reset mid-operation SHALL discard all queued entries and any pending redirect.
REQ-034 First push SHALL occur at first rising edge after reset_n deasserts; out_valid=1 one edge later.

Verification (DEPTH=4, ADDR_W=64, RESET_PC=0)
REQ-035 Fill: out_ready=0 after reset -> count 1,2,3,4 then holds 4; fetch_pc holds 0x10; head out_pc=0x0, out_pc_plus4=0x4.
REQ-036 Stream: out_ready=1 constantly -> out_pc 0x0,0x4,0x8,... one per cycle, count steady at 1.
REQ-037 Full push+pop: count=4, out_ready=1 one cycle -> count stays 4, head 0x0->0x4, tail gets 0x10.
REQ-038 Cond branch back: redirect, mode 00, redirect_pc=0x100, imm[18:0]=0x7FFFF -> queue flushed, two edges later out_pc=0xFC; mode 01 imm=0x0000010 at 0x100 -> out_pc=0x140.
REQ-039 Register branch misaligned: mode 10, redirect_reg=0x2003 -> target 0x2000, misalign pulses one cycle; wrap: mode 11 redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> out_pc=0x0.
REQ-040 Async reset mid-stream: reset_n low between edges with count=3 -> out_valid=0, count=0 before next edge; after release fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with circular prefetch queue and redirect target generation
module fetch_unit #(
  parameter int ADDR_W = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [1:0]                 redirect_mode,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic [25:0]                redirect_imm,
  input  logic [ADDR_W-1:0]          redirect_reg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       misalign
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] MODE_COND   = 2'b00;
  localparam logic [1:0] MODE_UNCOND = 2'b01;
  localparam logic [1:0] MODE_REG    = 2'b10;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     head_q, tail_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];

  logic              push, pop;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] off_cond, off_uncond;

  // Offsets are word offsets: sign-extend the field, then scale by 4.
  assign off_cond   = {{(ADDR_W-21){redirect_imm[18]}}, redirect_imm[18:0], 2'b00};
  assign off_uncond = {{(ADDR_W-28){redirect_imm[25]}}, redirect_imm[25:0], 2'b00};

  always_comb begin
    target = redirect_pc + ADDR_W'(4);
    case (redirect_mode)
      MODE_COND:   target = redirect_pc + off_cond;
      MODE_UNCOND: target = redirect_pc + off_uncond;
      MODE_REG:    target = {redirect_reg[ADDR_W-1:2], 2'b00};
      default:     target = redirect_pc + ADDR_W'(4);
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = !redirect && ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = target;
      count_d    = '0;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      misalign_q <= redirect && (redirect_mode == MODE_REG) && (redirect_reg[1:0] != 2'b00);
      if (redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop)  head_q <= head_q + PW'(1);
        if (push) tail_q <= tail_q + PW'(1);
      end
    end
  end

  // Queue storage needs no reset; the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]    <= fetch_pc_q;
      instr_q[tail_q] <= imem_rdata;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign count        = count_q;
  assign misalign     = misalign_q;
  assign out_pc       = out_valid ? pc_q[head_q] : '0;
  assign out_instr    = out_valid ? instr_q[head_q] : '0;
  assign out_pc_plus4 = out_valid ? (pc_q[head_q] + ADDR_W'(4)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [1:0]  redirect_mode;
  logic [63:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [63:0] redirect_reg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus4;
  logic [2:0]  count;
  logic        misalign;

  int total = 0;
  int bad = 0;

  fetch_unit #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_mode(redirect_mode), .redirect_pc(redirect_pc),
    .redirect_imm(redirect_imm), .redirect_reg(redirect_reg), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .count(count), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hDEAD_0000 ^ a[31:0];
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [63:0] pc);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_pc4"}, out_pc_plus4, pc + 64'd4);
    check({tag, "_instr"}, {32'h0, out_instr}, {32'h0, mem_word(pc)});
  endtask

  initial begin
    reset_n = 1'b0;
    redirect = 1'b0;
    redirect_mode = 2'b00;
    redirect_pc = '0;
    redirect_imm = '0;
    redirect_reg = '0;
    out_ready = 1'b0;
    #2;
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_pc4", out_pc_plus4, 64'h0);
    check("rst_instr", {32'h0, out_instr}, 64'h0);
    check("rst_mis", {63'h0, misalign}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    reset_n = 1'b1;

    // Fill with consumer stalled
    for (int i = 1; i <= 4; i++) begin
      tick;
      check($sformatf("fill_count%0d", i), {61'h0, count}, 64'(i));
    end
    check("fill_valid", {63'h0, out_valid}, 64'h1);
    tick;
    tick;
    check("full_hold_count", {61'h0, count}, 64'd4);
    check("full_hold_addr", imem_addr, 64'h10);
    head("full_head", 64'h0);

    // Push+pop at full, then keep streaming at full occupancy
    out_ready = 1'b1;
    tick;
    check("pp_count", {61'h0, count}, 64'd4);
    head("pp_head", 64'h4);
    tick;
    head("pp_head2", 64'h8);
    tick;
    tick;
    head("pp_tail", 64'h10);
    check("pp_count2", {61'h0, count}, 64'd4);

    // Conditional branch backwards, consumer still ready
    redirect = 1'b1;
    redirect_mode = 2'b00;
    redirect_pc = 64'h100;
    redirect_imm = 26'h007FFFF;
    tick;
    redirect = 1'b0;
    check("cond_count", {61'h0, count}, 64'h0);
    check("cond_valid", {63'h0, out_valid}, 64'h0);
    check("cond_addr", imem_addr, 64'hFC);
    tick;
    head("cond_head", 64'hFC);
    check("cond_cnt1", {61'h0, count}, 64'd1);
    tick;
    head("stream1", 64'h100);
    check("stream_cnt", {61'h0, count}, 64'd1);
    tick;
    head("stream2", 64'h104);

    // Unconditional forward
    redirect = 1'b1;
    redirect_mode = 2'b01;
    redirect_pc = 64'h100;
    redirect_imm = 26'h0000010;
    tick;
    redirect = 1'b0;
    check("unc_addr", imem_addr, 64'h140);
    tick;
    head("unc_head", 64'h140);

    // Misaligned register target
    redirect = 1'b1;
    redirect_mode = 2'b10;
    redirect_reg = 64'h2003;
    tick;
    redirect = 1'b0;
    check("reg_mis", {63'h0, misalign}, 64'h1);
    check("reg_addr", imem_addr, 64'h2000);
    tick;
    check("reg_mis_off", {63'h0, misalign}, 64'h0);
    head("reg_head", 64'h2000);

    // Aligned register target: no misalign pulse
    redirect = 1'b1;
    redirect_reg = 64'h3000;
    tick;
    redirect = 1'b0;
    check("reg_al_mis", {63'h0, misalign}, 64'h0);

    // Resync with address wrap; held redirect keeps the queue empty
    redirect = 1'b1;
    redirect_mode = 2'b11;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    check("hold_cnt1", {61'h0, count}, 64'h0);
    tick;
    check("hold_cnt2", {61'h0, count}, 64'h0);
    check("wrap_addr", imem_addr, 64'h0);
    redirect = 1'b0;
    out_ready = 1'b0;
    tick;
    head("wrap_head", 64'h0);
    tick;
    tick;
    check("pre_rst_cnt", {61'h0, count}, 64'd3);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {63'h0, out_valid}, 64'h0);
    check("arst_count", {61'h0, count}, 64'h0);
    check("arst_pc", out_pc, 64'h0);
    check("arst_addr", imem_addr, 64'h0);
    #1;
    reset_n = 1'b1;
    tick;
    check("rel_cnt", {61'h0, count}, 64'd1);
    head("rel_head", 64'h0);

    // Streaming from near-empty
    out_ready = 1'b1;
    tick;
    head("s1", 64'h4);
    check("s1_cnt", {61'h0, count}, 64'd1);
    tick;
    head("s2", 64'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
